// File: rtl/clk_switch_ctrl.sv
// Sequencer for the SCU glitch-free clock switch: waits for a stable PLL lock, steers sel_clk,
// then holds completion until the switch has settled. Define CLK_SW_FALLBACK_EN for auto-fallback.
module clk_switch_ctrl #(
    parameter int LOCK_CYC    = 16,
    parameter int SETTLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 13
) (
    input  logic clk0,
    input  logic rst_n,
    input  logic sw_req,
    input  logic sw_target,
    input  logic pll_lock,
    output logic sel_clk,
    output logic busy,
    output logic done,
    output logic err,
    output logic cur_src,
    output logic fallback
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOCK,
        SWITCH,
        SETTLE
    } state_e;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic             lock_meta_q, lock_s_q;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             target_q, target_d;
    logic             fb_mode_q, fb_mode_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cur_q, cur_d;
    logic             fb_q, fb_d;
    logic             fb_start;

`ifdef CLK_SW_FALLBACK_EN
    // Lock seen low on the previous IDLE cycle while running from clk1.
    logic lost_q;

    assign fb_start = (state_q == IDLE) && cur_q && !lock_s_q && lost_q;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            lost_q <= 1'b0;
        end else begin
            lost_q <= (state_q == IDLE) && cur_q && !lock_s_q;
        end
    end
`else
    assign fb_start = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= IDLE;
            stable_q    <= '0;
            tmo_q       <= '0;
            settle_q    <= '0;
            target_q    <= 1'b0;
            fb_mode_q   <= 1'b0;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_q       <= 1'b0;
            fb_q        <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            stable_q    <= stable_d;
            tmo_q       <= tmo_d;
            settle_q    <= settle_d;
            target_q    <= target_d;
            fb_mode_q   <= fb_mode_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cur_q       <= cur_d;
            fb_q        <= fb_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        tmo_d     = tmo_q;
        settle_d  = settle_q;
        target_d  = target_q;
        fb_mode_d = fb_mode_q;
        sel_d     = sel_q;
        cur_d     = cur_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fb_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fb_start) begin
                    target_d  = 1'b0;
                    fb_mode_d = 1'b1;
                    state_d   = SWITCH;
                end else if (sw_req) begin
                    if (sw_target == cur_q) begin
                        done_d = 1'b1;
                    end else if (!sw_target) begin
                        target_d  = 1'b0;
                        fb_mode_d = 1'b0;
                        state_d   = SWITCH;
                    end else begin
                        target_d  = 1'b1;
                        fb_mode_d = 1'b0;
                        stable_d  = '0;
                        tmo_d     = '0;
                        state_d   = WAIT_LOCK;
                    end
                end
            end
            WAIT_LOCK: begin
                stable_d = lock_s_q ? stable_q + CNT_ONE : '0;
                tmo_d    = tmo_q + CNT_ONE;
                // A lock that completes on the timeout cycle still counts as success.
                if (lock_s_q && (stable_q == LOCK_LAST)) begin
                    state_d = SWITCH;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            SWITCH: begin
                sel_d    = target_q;
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                settle_d = settle_q + CNT_ONE;
                if (settle_q == SETTLE_LAST) begin
                    cur_d   = target_q;
                    state_d = IDLE;
                    if (fb_mode_q) begin
                        fb_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign sel_clk  = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cur_src  = cur_q;
    assign fallback = fb_q;

endmodule
